// File: rtl/prog_delay_pkg.sv
// Shared definitions for the programmable delay line: FSM state encoding,
// DELAYTYPE selector strings and a constant-evaluable ceil(log2()) helper.
package prog_delay_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

    localparam string DT_STATIC  = "STATIC";
    localparam string DT_DYNAMIC = "DYNAMIC";

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prog_delay_tap.sv
// One delay channel: MAX_DELAY-stage shift register, tap select by code and
// registered output. code==0 bypasses the shift register (latency 1).
module prog_delay_tap #(
    parameter int WIDTH     = 1,
    parameter int MAX_DELAY = 63,
    parameter int CW        = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [CW-1:0]    code,
    output logic [WIDTH-1:0] Z
);

    logic [WIDTH-1:0] sr_q [MAX_DELAY];
    logic [WIDTH-1:0] tap_d;
    logic [WIDTH-1:0] z_q;

    // tap select: compare against every legal code instead of indexing, so
    // the index width never has to match the array depth
    always_comb begin
        tap_d = A;
        for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
            if (code == CW'(k)) tap_d = sr_q[k-1];
        end
    end

    // shift register advances every cycle; output register follows the tap
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned k = 0; k < MAX_DELAY; k++) sr_q[k] <= '0;
            z_q <= '0;
        end else begin
            sr_q[0] <= A;
            for (int unsigned k = 1; k < MAX_DELAY; k++) sr_q[k] <= sr_q[k-1];
            z_q <= tap_d;
        end
    end

    assign Z = z_q;

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel programmable delay line. Each channel delays A by code+1
// cycles. Codes are fixed at DEL_VALUE (DELAYTYPE="STATIC") or changed by
// LOAD / MOVE requests (DELAYTYPE="DYNAMIC").
// Build option: define PROG_DELAY_RAMP_EN to make LOAD ramp the code one
// step per cycle (BUSY high meanwhile); otherwise LOAD writes directly.
module prog_delay_line
    import prog_delay_pkg::*;
#(
    parameter int    CHANNELS  = 4,
    parameter int    WIDTH     = 1,
    parameter int    MAX_DELAY = 63,
    parameter string DELAYTYPE = "DYNAMIC",
    parameter int    DEL_VALUE = 0,
    localparam int   CW        = int'(clog2(unsigned'(MAX_DELAY + 1))),
    localparam int   SELW      = (CHANNELS > 1) ? int'(clog2(unsigned'(CHANNELS))) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CHANNELS*WIDTH-1:0] A,
    output logic [CHANNELS*WIDTH-1:0] Z,
    input  logic [SELW-1:0]           CH_SEL,
    input  logic                      LOAD,
    input  logic [CW-1:0]             DCNTL,
    input  logic                      MOVE,
    input  logic                      DIRECTION,
    output logic                      BUSY,
    output logic                      CFLAG,
    output logic [CW-1:0]             CODE_OUT
);

    localparam bit            IS_DYN = (DELAYTYPE != DT_STATIC);
    localparam logic [CW-1:0] MAXC   = CW'(MAX_DELAY);
    localparam logic [CW-1:0] DEFC   = CW'(DEL_VALUE);

    logic [CW-1:0] code_q [CHANNELS];
    logic [CW-1:0] code_d [CHANNELS];
    logic          cflag_q, cflag_d;
    logic [CW-1:0] sel_code;
    logic          sel_valid;
    logic          load_clamp;
    logic [CW-1:0] load_tgt;
    logic          fsm_idle;

`ifdef PROG_DELAY_RAMP_EN
    state_e        state_q, state_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic [CW-1:0] tgt_q, tgt_d;

    assign fsm_idle = (state_q == IDLE);
    assign BUSY     = IS_DYN && (state_q == RAMP);
`else
    assign fsm_idle = 1'b1;
    assign BUSY     = 1'b0;
`endif

    // read the code of the selected channel; out-of-range selects read 0
    always_comb begin
        sel_code  = '0;
        sel_valid = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (CH_SEL == SELW'(c)) begin
                sel_code  = code_q[c];
                sel_valid = 1'b1;
            end
        end
    end

    assign CODE_OUT   = sel_code;
    assign load_clamp = (DCNTL > MAXC);
    assign load_tgt   = load_clamp ? MAXC : DCNTL;
    assign CFLAG      = cflag_q;

    // code update: ramp step while busy, otherwise LOAD (wins) or MOVE
    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) code_d[c] = code_q[c];
        cflag_d = 1'b0;
`ifdef PROG_DELAY_RAMP_EN
        state_d = state_q;
        ch_d    = ch_q;
        tgt_d   = tgt_q;
        if (IS_DYN && !fsm_idle) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (ch_q == SELW'(c)) begin
                    if (code_q[c] < tgt_q) code_d[c] = code_q[c] + 1'b1;
                    else                   code_d[c] = code_q[c] - 1'b1;
                    if (code_d[c] == tgt_q) state_d = IDLE;
                end
            end
        end
`endif
        if (IS_DYN && fsm_idle && sel_valid) begin
            if (LOAD) begin
                cflag_d = load_clamp;
`ifdef PROG_DELAY_RAMP_EN
                ch_d  = CH_SEL;
                tgt_d = load_tgt;
                if (load_tgt != sel_code) state_d = RAMP;
`else
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    if (CH_SEL == SELW'(c)) code_d[c] = load_tgt;
                end
`endif
            end else if (MOVE) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    if (CH_SEL == SELW'(c)) begin
                        if (DIRECTION) begin
                            if (code_q[c] == MAXC) cflag_d = 1'b1;
                            else                   code_d[c] = code_q[c] + 1'b1;
                        end else begin
                            if (code_q[c] == '0)   cflag_d = 1'b1;
                            else                   code_d[c] = code_q[c] - 1'b1;
                        end
                    end
                end
            end
        end
    end

    // control registers; reset aborts any ramp and restores DEL_VALUE
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned c = 0; c < CHANNELS; c++) code_q[c] <= DEFC;
            cflag_q <= 1'b0;
`ifdef PROG_DELAY_RAMP_EN
            state_q <= IDLE;
            ch_q    <= '0;
            tgt_q   <= '0;
`endif
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) code_q[c] <= code_d[c];
            cflag_q <= cflag_d;
`ifdef PROG_DELAY_RAMP_EN
            state_q <= state_d;
            ch_q    <= ch_d;
            tgt_q   <= tgt_d;
`endif
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        prog_delay_tap #(
            .WIDTH     (WIDTH),
            .MAX_DELAY (MAX_DELAY),
            .CW        (CW)
        ) u_tap (
            .CLK  (CLK),
            .RST  (RST),
            .A    (A[c*WIDTH +: WIDTH]),
            .code (code_q[c]),
            .Z    (Z[c*WIDTH +: WIDTH])
        );
    end

endmodule
